// File: rtl/jc_spi_pkg.sv
// Shared types and constants for the jitter-cleaner SPI sequencer.
package jc_spi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARB       = 3'd1,
      ROM_RD    = 3'd2,
      LOAD      = 3'd3,
      ISSUE     = 3'd4,
      WAIT_DONE = 3'd5,
      ADVANCE   = 3'd6,
      SYNC_HI   = 3'd7
   } seq_state_e;

   localparam logic [31:0] END_MARKER   = 32'hFFFF_FFFF;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   function automatic logic is_end_marker(input logic [31:0] word);
      return (word == END_MARKER);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (host / sequencer) with a registered last-grant pointer.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_host,
   input  logic req_seq,
   input  logic update,
   output logic gnt_host,
   output logic gnt_seq
);

   // Set when the host was served last; cleared at reset so the host wins first contention.
   logic last_host_r;

   // Grant decode: contention goes to the side not served last
   always_comb begin
      gnt_host = 1'b0;
      gnt_seq  = 1'b0;
      if (req_host && req_seq) begin
         gnt_host = ~last_host_r;
         gnt_seq  = last_host_r;
      end else begin
         gnt_host = req_host;
         gnt_seq  = req_seq;
      end
   end

   // Last-grant pointer update on every accepted grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_host_r <= 1'b0;
      end else if (update && (gnt_host || gnt_seq)) begin
         last_host_r <= gnt_host;
      end
   end

endmodule

// File: rtl/jc_spi_sequencer.sv
// Auto-configuration sequencer and host arbiter for the shared jitter-cleaner SPI engine.
// Optional DONE watchdog is built when SPI_CFG_TIMEOUT_EN is defined.
module jc_spi_sequencer
   import jc_spi_pkg::*;
#(
   parameter int  NUM_CHIPS      = 3,
   parameter int  NUM_WORDS      = 16,
   parameter int  SYNC_CYCLES    = 8,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int AW             = $clog2(NUM_WORDS)
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          START,
   input  logic          HOST_REQ,
   input  logic [31:0]   HOST_WORD,
   input  logic [1:0]    HOST_SEL,
   output logic          HOST_ACK,
   output logic [31:0]   HOST_RDATA,
   output logic [AW+1:0] ROM_ADDR,
   input  logic [31:0]   ROM_DATA,
   output logic [31:0]   SPI_WORD,
   input  logic [31:0]   SPI_RDATA,
   output logic [1:0]    SPI_SEL,
   output logic          SPI_GO,
   input  logic          SPI_DONE,
   output logic          SYNC,
   output logic          BUSY,
   output logic          CFG_DONE,
   output logic          ERR
);

   localparam int            SCW       = $clog2(SYNC_CYCLES + 1);
   localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_CYCLES - 1);
   localparam logic [AW-1:0]  IDX_LAST  = AW'(NUM_WORDS - 1);
   localparam logic [1:0]     CHIP_LAST = 2'(NUM_CHIPS - 1);

   seq_state_e     state_r;
   seq_state_e     next_state_s;
   logic [1:0]     chip_r;
   logic [AW-1:0]  index_r;
   logic [SCW-1:0] sync_cnt_r;
   logic           seq_pending_r;
   logic           prog_done_r;
   logic           gnt_host_r;
   logic           marker_r;
   logic           gnt_host_s;
   logic           gnt_seq_s;
   logic           arb_take_s;
   logic           timeout_s;

   logic           host_ack_r;
   logic [31:0]    host_rdata_r;
   logic [AW+1:0]  rom_addr_r;
   logic [31:0]    spi_word_r;
   logic [1:0]     spi_sel_r;
   logic           spi_go_r;
   logic           sync_r;
   logic           busy_r;
   logic           cfg_done_r;

   assign arb_take_s = (state_r == ARB);

   rr_arb2 u_arb (
      .clk      (CLOCK),
      .rst      (RESET),
      .req_host (HOST_REQ),
      .req_seq  (seq_pending_r),
      .update   (arb_take_s),
      .gnt_host (gnt_host_s),
      .gnt_seq  (gnt_seq_s)
   );

`ifdef SPI_CFG_TIMEOUT_EN
   localparam int             WDW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   logic [WDW-1:0] wd_cnt_r;
   logic           err_r;

   assign timeout_s = (state_r == WAIT_DONE) && !SPI_DONE && (wd_cnt_r == WD_LAST);

   // DONE watchdog counter and sticky timeout flag
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         wd_cnt_r <= {WDW{1'b0}};
         err_r    <= 1'b0;
      end else begin
         if (state_r == WAIT_DONE) begin
            wd_cnt_r <= wd_cnt_r + WDW'(1);
         end else begin
            wd_cnt_r <= {WDW{1'b0}};
         end
         if ((state_r == IDLE) && START) begin
            err_r <= 1'b0;
         end else if (timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign ERR = err_r;
`else
   assign timeout_s = 1'b0;
   assign ERR       = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (START || HOST_REQ) begin
               next_state_s = ARB;
            end else begin
               next_state_s = IDLE;
            end
         end
         ARB: begin
            if (gnt_host_s) begin
               next_state_s = LOAD;
            end else if (gnt_seq_s) begin
               next_state_s = ROM_RD;
            end else if (prog_done_r) begin
               next_state_s = SYNC_HI;
            end else begin
               next_state_s = IDLE;
            end
         end
         ROM_RD: next_state_s = LOAD;
         LOAD: begin
            // An end-of-list word is never issued; it only forces a chip advance.
            if (!gnt_host_r && is_end_marker(ROM_DATA)) begin
               next_state_s = ADVANCE;
            end else begin
               next_state_s = ISSUE;
            end
         end
         ISSUE: next_state_s = WAIT_DONE;
         WAIT_DONE: begin
            if (SPI_DONE) begin
               next_state_s = ADVANCE;
            end else if (timeout_s) begin
               if (gnt_host_r) begin
                  next_state_s = ADVANCE;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = WAIT_DONE;
            end
         end
         ADVANCE: next_state_s = ARB;
         SYNC_HI: begin
            if (sync_cnt_r == SYNC_LAST) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = SYNC_HI;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register, sequencing counters and registered outputs
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_r       <= IDLE;
         chip_r        <= 2'd0;
         index_r       <= {AW{1'b0}};
         sync_cnt_r    <= {SCW{1'b0}};
         seq_pending_r <= 1'b0;
         prog_done_r   <= 1'b0;
         gnt_host_r    <= 1'b0;
         marker_r      <= 1'b0;
         host_ack_r    <= 1'b0;
         host_rdata_r  <= 32'h0000_0000;
         rom_addr_r    <= {(AW+2){1'b0}};
         spi_word_r    <= 32'h0000_0000;
         spi_sel_r     <= 2'd0;
         spi_go_r      <= 1'b0;
         sync_r        <= 1'b0;
         busy_r        <= 1'b0;
         cfg_done_r    <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         busy_r     <= (next_state_s != IDLE);
         spi_go_r   <= (next_state_s == ISSUE);
         sync_r     <= (next_state_s == SYNC_HI);
         host_ack_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (START) begin
                  seq_pending_r <= 1'b1;
                  prog_done_r   <= 1'b0;
                  cfg_done_r    <= 1'b0;
                  chip_r        <= 2'd0;
                  index_r       <= {AW{1'b0}};
               end
            end
            ARB: begin
               if (gnt_host_s || gnt_seq_s) begin
                  gnt_host_r <= gnt_host_s;
               end
               if (gnt_seq_s) begin
                  rom_addr_r <= {chip_r, index_r};
               end
            end
            LOAD: begin
               if (gnt_host_r) begin
                  spi_word_r <= HOST_WORD;
                  spi_sel_r  <= HOST_SEL;
                  marker_r   <= 1'b0;
               end else if (is_end_marker(ROM_DATA)) begin
                  marker_r   <= 1'b1;
               end else begin
                  spi_word_r <= ROM_DATA;
                  spi_sel_r  <= chip_r;
                  marker_r   <= 1'b0;
               end
            end
            WAIT_DONE: begin
               if (SPI_DONE) begin
                  if (gnt_host_r) begin
                     host_ack_r   <= 1'b1;
                     host_rdata_r <= SPI_RDATA;
                  end
               end else if (timeout_s) begin
                  if (gnt_host_r) begin
                     host_ack_r   <= 1'b1;
                     host_rdata_r <= TIMEOUT_DATA;
                  end else begin
                     seq_pending_r <= 1'b0;
                     chip_r        <= 2'd0;
                     index_r       <= {AW{1'b0}};
                  end
               end
            end
            ADVANCE: begin
               if (!gnt_host_r) begin
                  marker_r <= 1'b0;
                  if (marker_r || (index_r == IDX_LAST)) begin
                     index_r <= {AW{1'b0}};
                     if (chip_r == CHIP_LAST) begin
                        chip_r        <= 2'd0;
                        seq_pending_r <= 1'b0;
                        prog_done_r   <= 1'b1;
                     end else begin
                        chip_r <= chip_r + 2'd1;
                     end
                  end else begin
                     index_r <= index_r + AW'(1);
                  end
               end
            end
            SYNC_HI: begin
               if (sync_cnt_r == SYNC_LAST) begin
                  sync_cnt_r  <= {SCW{1'b0}};
                  cfg_done_r  <= 1'b1;
                  prog_done_r <= 1'b0;
               end else begin
                  sync_cnt_r <= sync_cnt_r + SCW'(1);
               end
            end
            default: begin
               sync_cnt_r <= {SCW{1'b0}};
            end
         endcase
      end
   end

   assign HOST_ACK   = host_ack_r;
   assign HOST_RDATA = host_rdata_r;
   assign ROM_ADDR   = rom_addr_r;
   assign SPI_WORD   = spi_word_r;
   assign SPI_SEL    = spi_sel_r;
   assign SPI_GO     = spi_go_r;
   assign SYNC       = sync_r;
   assign BUSY       = busy_r;
   assign CFG_DONE   = cfg_done_r;

endmodule

// File: doc/jc_spi_sequencer.md
# jc_spi_sequencer

Controller for the shared jitter-cleaner SPI engine. It runs an automatic configuration program for up to four clock chips, reading register words from a synchronous table and issuing one SPI transaction per word. It then pulses SYNC to align the chip outputs. Between words it arbitrates the engine round-robin with single-word host requests from the Wishbone register file. It sits between the register file and SPI_MODULE/SPI_MUX, in the CLK_1MHZ domain.

## Interface
Parameters:
- NUM_CHIPS, 3: chips sequenced, 1..4; chip index drives SPI_SEL.
- NUM_WORDS, 16: table slots per chip, power of two; AW = $clog2(NUM_WORDS).
- SYNC_CYCLES, 8: SYNC high width in clocks, ≥1.
- TIMEOUT_CYCLES, 1024: DONE watchdog limit (only with SPI_CFG_TIMEOUT_EN).

Ports:
- CLOCK in 1: the single clock (CLK_1MHZ).
- RESET in 1: asynchronous, active-high.
- START in 1: one-cycle pulse that starts the auto program.
- HOST_REQ in 1: level; held until HOST_ACK.
- HOST_WORD in 32: host SPI word.
- HOST_SEL in 2: host chip select.
- HOST_ACK out 1: one-cycle pulse; HOST_RDATA is valid in the same cycle.
- HOST_RDATA out 32: word shifted in during the host transaction.
- ROM_ADDR out 2+AW: {chip, index}, registered.
- ROM_DATA in 32: table word, valid one clock after ROM_ADDR.
- SPI_WORD out 32: to SPI_MODULE SPI_IN.
- SPI_RDATA in 32: from SPI_MODULE SPI_OUT.
- SPI_SEL out 2: to SPI_MUX SLAVE_SELECT.
- SPI_GO out 1: one-cycle start pulse.
- SPI_DONE in 1: one-cycle completion pulse from the engine.
- SYNC out 1: active-high sync; the top level inverts it.
- BUSY out 1: high whenever the block is not in IDLE.
- CFG_DONE out 1: sticky; set when the program completes.
- ERR out 1: sticky timeout flag.

## Operation
- Reset state:
  - All outputs are 0, ROM_ADDR is 0, FSM is IDLE, and chip/index counters are 0.
  - Round-robin pointer favours the host.
- FSM states: IDLE, ARB, ROM_RD, LOAD, ISSUE, WAIT_DONE, ADVANCE, SYNC_HI.
- IDLE:
  - START → clear CFG_DONE and ERR, set seq_pending, go to ARB.
  - HOST_REQ → go to ARB.
  - If both are seen in the same cycle, both are registered.
- START while BUSY is ignored.
- ARB grant rules:
  - Host only → host.
  - Sequencer only → sequencer.
  - Both → the side not served last, then the pointer flips.
  - Neither → go to SYNC_HI if the program just finished, else IDLE.
- Sequencer path: ROM_RD drives ROM_ADDR = {chip, index} → LOAD captures ROM_DATA into SPI_WORD and chip into SPI_SEL.
- Host path: LOAD captures HOST_WORD into SPI_WORD and HOST_SEL into SPI_SEL directly; there is no ROM_RD.
- ISSUE: SPI_GO high for exactly one cycle → WAIT_DONE.
- WAIT_DONE:
  - On SPI_DONE, a host grant pulses HOST_ACK and latches SPI_RDATA into HOST_RDATA.
  - Go to ADVANCE.
- ADVANCE (sequencer grants only; host grants return to ARB):
  - Word 0xFFFF_FFFF is an end-of-list marker. It is detected in LOAD and is not issued; it skips to the next chip.
  - Index wraps at NUM_WORDS-1 → next chip.
  - After chip NUM_CHIPS-1, seq_pending clears and the program is finished.
- SYNC_HI: SYNC high for SYNC_CYCLES clocks → set CFG_DONE → IDLE.
- SPI_WORD and SPI_SEL hold their values from LOAD until the next LOAD.
- RESET mid-transaction: immediate return to reset state. No HOST_ACK is issued. The SPI engine is not aborted.

## Timing
- START at edge k:
  - ARB at k+1, ROM_ADDR valid at k+2, ROM_DATA captured at k+3.
  - SPI_GO high in cycle k+4.
- Host request from IDLE: HOST_REQ at k → SPI_GO in cycle k+3 → HOST_ACK in the cycle after SPI_DONE is seen.
- Arbitration gap: 2 cycles minimum between SPI_DONE and the next SPI_GO.
- A SPI_DONE that arrives outside WAIT_DONE is ignored.

## Configuration
- SPI_CFG_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE. After TIMEOUT_CYCLES with no SPI_DONE, ERR is set.
  - A host grant then pulses HOST_ACK with HOST_RDATA = 0xDEAD_BEEF.
  - A sequencer grant abandons the program: seq_pending clears, there is no SYNC pulse, and CFG_DONE stays 0. FSM → IDLE.
- Undefined: WAIT_DONE waits indefinitely, and ERR is tied to 0.

## Structure
- Package jc_spi_pkg holds:
  - the state enum;
  - END_MARKER = 32'hFFFF_FFFF;
  - TIMEOUT_DATA = 32'hDEAD_BEEF.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with a registered last-grant pointer.
- The remaining logic is a single FSM.

## Test plan
- Program run: NUM_CHIPS=3, NUM_WORDS=4, all words distinct, START →
  - 12 SPI_GO pulses with ROM_ADDR order 0..3, 4..7, 8..11 and SPI_SEL 0,0,0,0,1,…,2;
  - then SYNC high for exactly 8 cycles, then CFG_DONE=1.
- Early end: chip1 word1 = 0xFFFF_FFFF → chip1 issues only word0, then chip2 starts at index 0; 9 GOs total.
- Host alone: HOST_WORD=0x1234_5678, HOST_SEL=2, model returns 0xA5A5_0001 → SPI_SEL=2, one GO, HOST_ACK with HOST_RDATA=0xA5A5_0001.
- Contention: HOST_REQ held during the program → grants alternate sequencer/host, at most one host transaction between consecutive sequencer words, and the program still completes.
- Timeout (macro on): model never sends DONE → ERR=1 after 1024 cycles, BUSY=0, CFG_DONE=0, and no SYNC pulse.
- Reset mid-WAIT_DONE → all outputs 0 immediately; a subsequent START reruns from ROM_ADDR 0.
